// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the NoC credit link and its monitor.
package noc_link_pkg;

    // Wormhole packet tracking state, advanced only on accepted flits.
    typedef enum logic {
        LINK_IDLE,
        LINK_IN_PKT
    } link_state_t;

    // Saturating increment: holds at max_value instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/noc_credit_link_if.sv
// Router-to-router flit/credit bundle. The master drives the flit and
// consumes credits; the slave consumes flits and returns credits.
interface noc_credit_link_if #(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 4
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    modport master (output data, dest, is_tail, send, input  credit);
    modport slave  (input  data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_link_stage.sv
// Generic fixed-latency shift register; zero stages degenerates to a wire.
// Bits set in RESET_MASK are cleared on reset, the rest are never reset.
module noc_link_stage #(
    parameter int                WIDTH      = 1,
    parameter int                NUM_STAGES = 0,
    parameter logic [WIDTH-1:0]  RESET_MASK = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o
);
    if (NUM_STAGES == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign d_o = d_i;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [NUM_STAGES];

        // Shift the word one stage per cycle; masked control bits clear on reset.
        // For unmasked bits both branches are identical, so no reset logic results.
        always_ff @(posedge clk_i) begin
            stage_q[0] <= rst_i ? (d_i & ~RESET_MASK) : d_i;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_q[i] <= rst_i ? (stage_q[i-1] & ~RESET_MASK) : stage_q[i-1];
            end
        end

        assign d_o = stage_q[NUM_STAGES-1];
    end
endmodule

// File: rtl/noc_credit_link.sv
// Pipelined router-to-router link with an inline monitor that tracks
// upstream credits, counts flits/packets and flags protocol violations.
module noc_credit_link
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH      = 128,
    parameter int DEST_WIDTH      = 4,
    parameter int NUM_PIPELINE    = 0,
    parameter int CREDIT_PIPELINE = NUM_PIPELINE,
    parameter int RX_BUFFER_DEPTH = 1,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                               clk_noc,
    input  logic                               rst_noc_sync,
    noc_credit_link_if.slave                   up_if,
    noc_credit_link_if.master                  dn_if,
    input  logic                               stat_clear,
    output logic [$clog2(RX_BUFFER_DEPTH+1)-1:0] credits_avail,
    output logic [STAT_WIDTH-1:0]              flit_count,
    output logic [STAT_WIDTH-1:0]              packet_count,
    output logic                               err_credit_ovf,
    output logic                               err_credit_unf,
    output logic                               err_packet
);
    localparam int              CW       = $clog2(RX_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(RX_BUFFER_DEPTH);
    localparam logic [63:0]     STAT_MAX = (64'd1 << STAT_WIDTH) - 64'd1;
    localparam int              FWD_W    = FLIT_WIDTH + DEST_WIDTH + 2;
    localparam logic [FWD_W-1:0] FWD_MASK = {2'b11, {(FLIT_WIDTH + DEST_WIDTH){1'b0}}};

    logic [FWD_W-1:0] fwd_in, fwd_out;

    assign fwd_in = {up_if.send, up_if.is_tail, up_if.dest, up_if.data};
    assign {dn_if.send, dn_if.is_tail, dn_if.dest, dn_if.data} = fwd_out;

    noc_link_stage #(
        .WIDTH      (FWD_W),
        .NUM_STAGES (NUM_PIPELINE),
        .RESET_MASK (FWD_MASK)
    ) u_fwd (
        .clk_i (clk_noc),
        .rst_i (rst_noc_sync),
        .d_i   (fwd_in),
        .d_o   (fwd_out)
    );

    noc_link_stage #(
        .WIDTH      (1),
        .NUM_STAGES (CREDIT_PIPELINE),
        .RESET_MASK (1'b1)
    ) u_credit (
        .clk_i (clk_noc),
        .rst_i (rst_noc_sync),
        .d_i   (dn_if.credit),
        .d_o   (up_if.credit)
    );

    // Monitor observes the upstream side: flits leaving the router, credits arriving.
    logic snd, crd;
    assign snd = up_if.send;
    assign crd = up_if.credit;

    logic [CW-1:0]         credit_q, credit_d;
    logic [STAT_WIDTH-1:0] flit_q, flit_d, pkt_q, pkt_d;
    logic                  ovf_q, unf_q, ovf_evt, unf_evt;
    link_state_t           state_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  err_packet_q, pkt_err_evt;

    // Credit next-state: send and return in one cycle cancel; out-of-range moves hold and flag.
    always_comb begin
        credit_d = credit_q;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (snd && !crd) begin
            if (credit_q == '0) ovf_evt = 1'b1;
            else                credit_d = credit_q - CW'(1);
        end else if (crd && !snd) begin
            if (credit_q == CRED_MAX) unf_evt = 1'b1;
            else                      credit_d = credit_q + CW'(1);
        end
    end

    // Statistics next-state with saturation.
    always_comb begin
        flit_d = flit_q;
        pkt_d  = pkt_q;
        if (snd) begin
            flit_d = STAT_WIDTH'(sat_inc(64'(flit_q), STAT_MAX));
            if (up_if.is_tail) pkt_d = STAT_WIDTH'(sat_inc(64'(pkt_q), STAT_MAX));
        end
    end

    // Credit counter, stats and sticky credit errors; clear drops same-cycle events.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_q <= CRED_MAX;
            flit_q   <= '0;
            pkt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            if (stat_clear) begin
                flit_q <= '0;
                pkt_q  <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                flit_q <= flit_d;
                pkt_q  <= pkt_d;
                ovf_q  <= ovf_q | ovf_evt;
                unf_q  <= unf_q | unf_evt;
            end
        end
    end

    assign pkt_err_evt = (state_q == LINK_IN_PKT) && snd && (up_if.dest != dest_q);

    // Packet FSM enforcing a constant dest across all flits of one wormhole packet.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q      <= LINK_IDLE;
            dest_q       <= '0;
            err_packet_q <= 1'b0;
        end else begin
            if (state_q == LINK_IDLE) begin
                if (snd && !up_if.is_tail) begin
                    state_q <= LINK_IN_PKT;
                    dest_q  <= up_if.dest;
                end
            end else begin
                if (snd && up_if.is_tail) state_q <= LINK_IDLE;
            end
            if (stat_clear)       err_packet_q <= 1'b0;
            else if (pkt_err_evt) err_packet_q <= 1'b1;
        end
    end

    assign credits_avail  = credit_q;
    assign flit_count     = flit_q;
    assign packet_count   = pkt_q;
    assign err_credit_ovf = ovf_q;
    assign err_credit_unf = unf_q;
    assign err_packet     = err_packet_q;
endmodule

// File: tb/tb_noc_credit_link.sv
// Directed bench for noc_credit_link using three configurations:
// A: 2-stage forward / 1-stage credit, depth 4, 4-bit stats.
// B: 3-stage forward / 3-stage credit, depth 4 (reset with flits in flight).
// C: pass-through, depth 1.
module tb_noc_credit_link;
    import noc_link_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr_a, clr_b, clr_c;

    always #5 clk = ~clk;

    noc_credit_link_if #(.FLIT_WIDTH(8), .DEST_WIDTH(4)) up_a(), dn_a(), up_b(), dn_b(), up_c(), dn_c();

    logic [2:0] cr_a, cr_b;
    logic [0:0] cr_c;
    logic [3:0] fc_a, pc_a;
    logic [31:0] fc_b, pc_b;
    logic [7:0] fc_c, pc_c;
    logic ovf_a, unf_a, pe_a, ovf_b, unf_b, pe_b, ovf_c, unf_c, pe_c;

    noc_credit_link #(.FLIT_WIDTH(8), .DEST_WIDTH(4), .NUM_PIPELINE(2), .CREDIT_PIPELINE(1),
                      .RX_BUFFER_DEPTH(4), .STAT_WIDTH(4)) dut_a (
        .clk_noc(clk), .rst_noc_sync(rst), .up_if(up_a), .dn_if(dn_a), .stat_clear(clr_a),
        .credits_avail(cr_a), .flit_count(fc_a), .packet_count(pc_a),
        .err_credit_ovf(ovf_a), .err_credit_unf(unf_a), .err_packet(pe_a));

    noc_credit_link #(.FLIT_WIDTH(8), .DEST_WIDTH(4), .NUM_PIPELINE(3), .CREDIT_PIPELINE(3),
                      .RX_BUFFER_DEPTH(4), .STAT_WIDTH(32)) dut_b (
        .clk_noc(clk), .rst_noc_sync(rst), .up_if(up_b), .dn_if(dn_b), .stat_clear(clr_b),
        .credits_avail(cr_b), .flit_count(fc_b), .packet_count(pc_b),
        .err_credit_ovf(ovf_b), .err_credit_unf(unf_b), .err_packet(pe_b));

    noc_credit_link #(.FLIT_WIDTH(8), .DEST_WIDTH(4), .NUM_PIPELINE(0), .CREDIT_PIPELINE(0),
                      .RX_BUFFER_DEPTH(1), .STAT_WIDTH(8)) dut_c (
        .clk_noc(clk), .rst_noc_sync(rst), .up_if(up_c), .dn_if(dn_c), .stat_clear(clr_c),
        .credits_avail(cr_c), .flit_count(fc_c), .packet_count(pc_c),
        .err_credit_ovf(ovf_c), .err_credit_unf(unf_c), .err_packet(pe_c));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        up_a.data = '0; up_a.dest = '0; up_a.is_tail = 1'b0; up_a.send = 1'b0; dn_a.credit = 1'b0;
        up_b.data = '0; up_b.dest = '0; up_b.is_tail = 1'b0; up_b.send = 1'b0; dn_b.credit = 1'b0;
        up_c.data = '0; up_c.dest = '0; up_c.is_tail = 1'b0; up_c.send = 1'b0; dn_c.credit = 1'b0;

        // Pass-through config: send_out follows send_in even while in reset.
        up_c.send = 1'b1;
        #1;
        check_val("c_send_comb_in_rst", dn_c.send, 1);
        up_c.send = 1'b0;
        #1;
        check_val("c_send_comb_low", dn_c.send, 0);

        step();
        step();
        check_val("rst_send_out", dn_a.send, 0);
        check_val("rst_credit_out", up_a.credit, 0);
        check_val("rst_credits", cr_a, 4);
        check_val("rst_flits", fc_a, 0);
        check_val("rst_pkts", pc_a, 0);
        check_val("rst_errs", {ovf_a, unf_a, pe_a}, 0);
        rst = 1'b0;

        // Forward latency 2 and credit latency 1.
        up_a.send = 1'b1; up_a.data = 8'hA5; up_a.dest = 4'd3; up_a.is_tail = 1'b1;
        step();
        up_a.send = 1'b0; up_a.data = 8'h00; up_a.dest = 4'd0;
        check_val("lat_send_c1", dn_a.send, 0);
        step();
        check_val("lat_send_c2", dn_a.send, 1);
        check_val("lat_data_c2", dn_a.data, 8'hA5);
        check_val("lat_dest_c2", dn_a.dest, 3);
        check_val("lat_tail_c2", dn_a.is_tail, 1);
        step();
        check_val("lat_send_c3", dn_a.send, 0);
        check_val("lat_credits_after_send", cr_a, 3);
        dn_a.credit = 1'b1;
        step();
        dn_a.credit = 1'b0;
        check_val("cred_out_c1", up_a.credit, 1);
        step();
        check_val("cred_out_c2", up_a.credit, 0);
        check_val("cred_restored", cr_a, 4);

        // Back-to-back sends drain credits; fifth send overflows.
        do_reset();
        up_a.send = 1'b1; up_a.is_tail = 1'b1; up_a.dest = 4'd1;
        check_val("drain_0", cr_a, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("drain_%0d", i + 1), cr_a, 64'(3 - i));
        end
        check_val("ovf_before", ovf_a, 0);
        step();
        up_a.send = 1'b0;
        check_val("ovf_set", ovf_a, 1);
        check_val("ovf_hold0", cr_a, 0);

        // Return two credits, then a send and a credit in the same cycle.
        dn_a.credit = 1'b1;
        step();
        step();
        dn_a.credit = 1'b0;
        step();
        check_val("refill_2", cr_a, 2);
        dn_a.credit = 1'b1;
        step();
        dn_a.credit = 1'b0;
        up_a.send = 1'b1;
        step();
        up_a.send = 1'b0;
        check_val("same_cycle_hold2", cr_a, 2);

        // Over-return at full depth flags underflow and holds.
        check_val("unf_before", unf_a, 0);
        dn_a.credit = 1'b1;
        step();
        step();
        step();
        dn_a.credit = 1'b0;
        check_val("refill_4", cr_a, 4);
        step();
        check_val("unf_set", unf_a, 1);
        check_val("unf_hold4", cr_a, 4);

        // 3-flit packet to 5 then single-flit to 2.
        do_reset();
        up_a.send = 1'b1; up_a.dest = 4'd5; up_a.is_tail = 1'b0;
        step();
        step();
        up_a.is_tail = 1'b1;
        step();
        up_a.dest = 4'd2;
        step();
        up_a.send = 1'b0; up_a.is_tail = 1'b0;
        check_val("pkt_count", pc_a, 2);
        check_val("pkt_flits", fc_a, 4);
        check_val("pkt_no_err", pe_a, 0);
        // Dest change mid-packet.
        up_a.send = 1'b1; up_a.dest = 4'd5; up_a.is_tail = 1'b0;
        step();
        up_a.dest = 4'd6; up_a.is_tail = 1'b1;
        step();
        up_a.send = 1'b0; up_a.is_tail = 1'b0;
        check_val("pkt_err_set", pe_a, 1);

        // Saturating 4-bit counters, then stat_clear.
        do_reset();
        up_a.send = 1'b1; up_a.is_tail = 1'b1; up_a.dest = 4'd0;
        repeat (17) step();
        up_a.send = 1'b0;
        check_val("sat_flits", fc_a, 15);
        check_val("sat_pkts", pc_a, 15);
        check_val("sat_ovf", ovf_a, 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check_val("clr_flits", fc_a, 0);
        check_val("clr_pkts", pc_a, 0);
        check_val("clr_ovf", ovf_a, 0);
        check_val("clr_credits_kept", cr_a, 0);

        // Depth-1 pass-through link overflows on its second send.
        up_c.send = 1'b1; up_c.is_tail = 1'b1;
        step();
        check_val("c_credits_0", cr_c, 0);
        step();
        up_c.send = 1'b0;
        check_val("c_ovf", ovf_c, 1);

        // Reset with two flits in flight in the 3-stage link.
        up_b.send = 1'b1; up_b.is_tail = 1'b1; up_b.data = 8'h3C;
        step();
        step();
        up_b.send = 1'b0;
        check_val("b_credits_inflight", cr_b, 2);
        rst = 1'b1;
        step();
        check_val("b_rst_send", dn_b.send, 0);
        check_val("b_rst_credits", cr_b, 4);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("b_post_rst_send_%0d", i), dn_b.send, 0);
        end
        check_val("b_post_rst_flits", fc_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
